// File: rtl/score_pkg.sv
// Shared types and defaults for the score tracker and its BCD converter.
package score_pkg;

    localparam int SCORE_W_DEF   = 8;
    localparam int MAX_SCORE_DEF = 140;

    typedef enum logic {
        PLAY,
        OVER
    } game_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } bcd_state_t;

    // Double-dabble digit correction: a digit of 5 or more gets +3 so that
    // the following left shift carries into the next decimal digit.
    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Reusable for any display path: pulse start while idle, read bcd after done.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [W-1:0]          bin,
    input  logic                  start,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  done
);

    localparam int CNT_W = $clog2(W + 1);

    bcd_state_t              r_state;
    logic [W-1:0]            r_bin;
    logic [4*DIGITS-1:0]     r_acc;
    logic [4*DIGITS-1:0]     r_bcd;
    logic [CNT_W-1:0]        r_cnt;

    logic [4*DIGITS-1:0]     w_adj;
    logic [4*DIGITS-1:0]     w_acc_next;

    // One double-dabble step: correct every digit, then shift in the next bin MSB.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_adj[4*i +: 4] = dd_adjust(r_acc[4*i +: 4]);
        end
        w_acc_next = {w_adj[4*DIGITS-2:0], r_bin[W-1]};
    end

    // Converter FSM; the operand is latched on start so later input changes
    // cannot corrupt a conversion in flight. bcd is written on the final shift.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_acc   <= '0;
                    r_cnt   <= CNT_W'(W);
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_acc <= w_acc_next;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_acc_next;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
    assign bcd  = r_bcd;

endmodule

// File: rtl/score_tracker_param.sv
// Game score tracker: edge-detected scoring with saturation, high score,
// PLAY/OVER game FSM and a BCD display feed with a valid flag.
module score_tracker_param
    import score_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int MAX_SCORE = MAX_SCORE_DEF,
    parameter int POINTS    = 1,
    parameter int DIGITS    = 3
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  goodColl,
    input  logic                  badColl,
    input  logic                  restart,
    output logic [SCORE_W-1:0]    current_score,
    output logic [SCORE_W-1:0]    high_score,
    output logic [SCORE_W-1:0]    dispScore,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic                  bcd_valid,
    output logic                  isGameComplete,
    output logic                  game_over
);

    localparam logic [SCORE_W:0]   MAX_EXT    = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W:0]   POINTS_EXT = (SCORE_W+1)'(POINTS);
    localparam logic [SCORE_W-1:0] MAX_VAL    = SCORE_W'(MAX_SCORE);

    game_state_t          r_state;
    logic                 r_good_q;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_high;
    logic [SCORE_W-1:0]   r_disp;
    logic                 r_complete;
    logic [SCORE_W-1:0]   r_pending;
    logic [SCORE_W-1:0]   r_last_conv;

    logic                 w_good_edge;
    logic [SCORE_W:0]     w_sum;
    logic [SCORE_W-1:0]   w_next_score;
    logic [SCORE_W-1:0]   w_next_high;
    game_state_t          w_next_state;
    logic                 w_start;
    logic                 w_busy;
    logic                 w_done;

    assign w_good_edge = goodColl & ~r_good_q;

    // Next score/state; the sum carries one extra bit so saturation sees overflow.
    always_comb begin
        w_next_score = r_score;
        w_next_state = r_state;
        w_sum        = {1'b0, r_score} + POINTS_EXT;
        case (r_state)
            PLAY: begin
                if (badColl) begin
                    w_next_state = OVER;
                end else if (w_good_edge) begin
                    w_next_score = (w_sum >= MAX_EXT) ? MAX_VAL : w_sum[SCORE_W-1:0];
                    if (w_next_score == MAX_VAL) begin
                        w_next_state = OVER;
                    end
                end
            end
            OVER: begin
                if (restart) begin
                    w_next_score = '0;
                    w_next_state = PLAY;
                end
            end
            default: w_next_state = PLAY;
        endcase
        w_next_high = (w_next_score > r_high) ? w_next_score : r_high;
    end

    // Game registers; dispScore follows next-state values so it moves with the score.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= PLAY;
            r_good_q   <= 1'b0;
            r_score    <= '0;
            r_high     <= '0;
            r_disp     <= '0;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_good_q   <= goodColl;
            r_score    <= w_next_score;
            r_high     <= w_next_high;
            r_disp     <= (w_next_state == OVER) ? w_next_high : w_next_score;
            r_complete <= (r_state == PLAY) && (w_next_state == OVER);
        end
    end

    // Remember which value the converter is working on and which one is shown,
    // so a display change during a conversion re-triggers once it finishes.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pending   <= '0;
            r_last_conv <= '0;
        end else begin
            if (w_start) r_pending   <= r_disp;
            if (w_done)  r_last_conv <= r_pending;
        end
    end

    assign w_start = !w_busy && (r_disp != r_last_conv);

    bin2bcd_seq #(
        .W      (SCORE_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .nRst  (nRst),
        .bin   (r_disp),
        .start (w_start),
        .busy  (w_busy),
        .bcd   (bcd_digits),
        .done  (w_done)
    );

    assign current_score  = r_score;
    assign high_score     = r_high;
    assign dispScore      = r_disp;
    assign bcd_valid      = !w_busy && (r_disp == r_last_conv);
    assign isGameComplete = r_complete;
    assign game_over      = (r_state == OVER);

endmodule

// File: tb/tb_score_tracker_param.sv
// Self-checking bench for score_tracker_param (POINTS=3, MAX_SCORE=140).
// A behavioural model tracks the game rules and the display conversion
// latency; directed scenarios are followed by a randomized soak.
module tb_score_tracker_param;

    localparam int W    = 8;
    localparam int MAXS = 140;
    localparam int P    = 3;
    localparam int D    = 3;

    logic              clk = 1'b0;
    logic              nRst;
    logic              goodColl;
    logic              badColl;
    logic              restart;
    logic [W-1:0]      current_score;
    logic [W-1:0]      high_score;
    logic [W-1:0]      dispScore;
    logic [4*D-1:0]    bcd_digits;
    logic              bcd_valid;
    logic              isGameComplete;
    logic              game_over;

    int checks = 0;
    int errors = 0;

    score_tracker_param #(
        .SCORE_W   (W),
        .MAX_SCORE (MAXS),
        .POINTS    (P),
        .DIGITS    (D)
    ) dut (
        .clk            (clk),
        .nRst           (nRst),
        .goodColl       (goodColl),
        .badColl        (badColl),
        .restart        (restart),
        .current_score  (current_score),
        .high_score     (high_score),
        .dispScore      (dispScore),
        .bcd_digits     (bcd_digits),
        .bcd_valid      (bcd_valid),
        .isGameComplete (isGameComplete),
        .game_over      (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int             m_score, m_high, m_disp;
    bit             m_over, m_complete, m_prev_good;
    int             m_busy_left;   // edges until the converter is idle again
    int             m_val, m_last;
    logic [4*D-1:0] m_bcd;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int             x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_score = 0; m_high = 0; m_disp = 0;
        m_over = 0; m_complete = 0; m_prev_good = 0;
        m_busy_left = 0; m_val = 0; m_last = 0;
        m_bcd = '0;
    endtask

    // Advance the model by one clock edge using the inputs applied for it.
    task automatic model_clock();
        bit e;
        // Display conversion: starts when idle and stale, result appears
        // W+1 edges after the start edge, idle again one edge later.
        if (m_busy_left == 0) begin
            if (m_disp != m_last) begin
                m_val       = m_disp;
                m_busy_left = W + 2;
            end
        end else begin
            m_busy_left--;
            if (m_busy_left == 1) m_bcd  = to_bcd(m_val);
            if (m_busy_left == 0) m_last = m_val;
        end
        // Game rules
        e           = goodColl && !m_prev_good;
        m_prev_good = goodColl;
        m_complete  = 0;
        if (!m_over) begin
            if (badColl) begin
                m_over = 1; m_complete = 1;
            end else if (e) begin
                m_score = (m_score + P > MAXS) ? MAXS : m_score + P;
                if (m_score == MAXS) begin
                    m_over = 1; m_complete = 1;
                end
            end
        end else if (restart) begin
            m_score = 0; m_over = 0;
        end
        if (m_score > m_high) m_high = m_score;
        m_disp = m_over ? m_high : m_score;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("current_score", 32'(current_score), 32'(m_score));
        check("high_score", 32'(high_score), 32'(m_high));
        check("dispScore", 32'(dispScore), 32'(m_disp));
        check("game_over", 32'(game_over), 32'(m_over));
        check("isGameComplete", 32'(isGameComplete), 32'(m_complete));
        check("bcd_digits", 32'(bcd_digits), 32'(m_bcd));
        check("bcd_valid", 32'(bcd_valid), 32'((m_busy_left == 0) && (m_disp == m_last)));
    endtask

    // Called at a negedge; applies inputs, clocks once, checks, returns at the next negedge.
    task automatic cycle(input bit g, input bit b, input bit r);
        goodColl = g; badColl = b; restart = r;
        @(posedge clk);
        model_clock();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            cycle(1, 0, 0);
            cycle(0, 0, 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0);
    endtask

    // Asynchronous reset away from any edge; outputs must clear with no clock.
    task automatic do_reset();
        goodColl = 0; badColl = 0; restart = 0;
        #2;
        nRst = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_bcd_valid", 32'(bcd_valid), 32'd1);
        @(negedge clk);
        nRst = 1'b1;
    endtask

    bit seen_final;
    bit saw_invalid;

    initial begin
        // Reset with goodColl held high: it must score exactly once after release.
        nRst = 1'b0; goodColl = 1'b1; badColl = 1'b0; restart = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b1;

        // Edge-only scoring: high for 5 cycles, low, then two single-cycle pulses.
        repeat (5) cycle(1, 0, 0);
        check("held_high_scores_once", 32'(current_score), 32'(P));
        cycle(0, 0, 0);
        edges(2);
        check("edge_score", 32'(current_score), 32'(3 * P));
        check("edge_disp", 32'(dispScore), 32'(3 * P));
        idle(30);
        check("edge_bcd", 32'(bcd_digits), 32'h009);
        check("edge_bcd_valid", 32'(bcd_valid), 32'd1);

        // Conversion latency from a quiet converter: score 9 -> 12.
        cycle(1, 0, 0);
        repeat (9) cycle(0, 0, 0);
        check("latency_before", 32'(bcd_digits), 32'h009);
        cycle(0, 0, 0);
        check("latency_at", 32'(bcd_digits), 32'h012);
        check("latency_valid_low", 32'(bcd_valid), 32'd0);
        cycle(0, 0, 0);
        check("latency_valid_high", 32'(bcd_valid), 32'd1);

        // Saturation: 46 edges -> 138, 47th saturates at 140 and ends the game.
        do_reset();
        edges(46);
        check("sat_138", 32'(current_score), 32'd138);
        cycle(1, 0, 0);
        check("sat_140", 32'(current_score), 32'd140);
        check("sat_complete", 32'(isGameComplete), 32'd1);
        check("sat_over", 32'(game_over), 32'd1);
        cycle(0, 0, 0);
        check("sat_complete_pulse", 32'(isGameComplete), 32'd0);
        edges(3);
        check("sat_frozen", 32'(current_score), 32'd140);
        idle(12);
        check("sat_bcd", 32'(bcd_digits), 32'h140);

        // High score retention across a restart.
        do_reset();
        edges(12);
        cycle(0, 1, 0);
        check("hs_high", 32'(high_score), 32'd36);
        check("hs_disp", 32'(dispScore), 32'd36);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        check("hs_restart_cur", 32'(current_score), 32'd0);
        check("hs_restart_disp", 32'(dispScore), 32'd0);
        check("hs_restart_over", 32'(game_over), 32'd0);
        edges(4);
        cycle(0, 1, 0);
        check("hs_kept", 32'(high_score), 32'd36);
        check("hs_disp2", 32'(dispScore), 32'd36);
        check("hs_cur2", 32'(current_score), 32'd12);
        edges(2);
        check("over_ignores_good", 32'(current_score), 32'd12);

        // Good edge and badColl together: bad wins.
        do_reset();
        edges(7);
        cycle(1, 1, 0);
        check("sim_cur", 32'(current_score), 32'd21);
        check("sim_high", 32'(high_score), 32'd21);
        check("sim_over", 32'(game_over), 32'd1);
        check("sim_complete", 32'(isGameComplete), 32'd1);
        cycle(0, 0, 0);
        check("sim_pulse_end", 32'(isGameComplete), 32'd0);

        // Overlapping conversions: 9 -> 12 -> 15 two cycles apart.
        do_reset();
        edges(3);
        idle(20);
        seen_final = 0; saw_invalid = 0;
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (30) begin
            cycle(0, 0, 0);
            if (!bcd_valid) saw_invalid = 1;
            if (bcd_digits == 12'h015) seen_final = 1;
            if (seen_final) check("ovl_no_stale", 32'(bcd_digits == 12'h012), 32'd0);
        end
        check("ovl_valid_dropped", 32'(saw_invalid), 32'd1);
        check("ovl_final_bcd", 32'(bcd_digits), 32'h015);
        check("ovl_final_valid", 32'(bcd_valid), 32'd1);

        // Randomized soak with one asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
